vga_vram_arbiter: RTL and testbench
===================================

Name: vga_vram_arbiter

Overview:
- Owns the single-port video RAM (VRAM) shared by the VGA display path and a writer (CPU/pattern generator).
- Consumes VGA_Control timing (column_count, row_count, display-enable) and issues one pixel read per cycle during active display.
- Buffers writer requests in a small FIFO and drains them only in blanking cycles.
- Provides a sequenced clear-screen sweep that also runs only in blanking cycles.

Parameters:
- H_ACTIVE, 64, visible columns per line
- V_ACTIVE, 480, visible lines per frame
- ADDR_W, 15, VRAM address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE)
- DATA_W, 3, pixel width (RGB 1-1-1)
- FIFO_DEPTH, 4, writer FIFO entries (power of 2)

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- iDisplayEn  in  1  high while timing is in horizontal display and row_count < V_ACTIVE
- iColumn  in  10  column_count from timing
- iRow  in  10  row_count from timing
- iWrReq  in  1  writer request
- iWrAddr  in  ADDR_W  writer pixel address
- iWrData  in  DATA_W  writer pixel value
- oWrFull  out  1  FIFO full; a request is ignored while this is high
- iClearReq  in  1  single-cycle pulse to start a clear sweep
- iClearColor  in  DATA_W  fill value, sampled when the clear is accepted
- oClearBusy  out  1  clear sweep in progress
- oRamAddr  out  ADDR_W  VRAM address (combinational)
- oRamWe  out  1  VRAM write enable (combinational)
- oRamWData  out  DATA_W  VRAM write data (combinational)
- iRamRData  in  DATA_W  VRAM read data, valid one cycle after the address
- oPixel  out  DATA_W  pixel to the DAC
- oDropCount  out  8  saturating count of dropped out-of-range writes

Behaviour:
- Reset values: FIFO empty, oWrFull=0, oClearBusy=0, oPixel=0, oDropCount=0, state ST_IDLE, clear address=0. Reset mid-clear or mid-drain aborts immediately; FIFO contents are discarded.
- Per-cycle slot priority: display read > clear write > FIFO drain.
- Display slot (iDisplayEn=1):
  - oRamAddr = iRow*H_ACTIVE + iColumn, truncated to ADDR_W; oRamWe=0.
  - The arithmetic is a shift-add at full width; no multiplier is inferred when H_ACTIVE is a power of 2.
- Pixel output: a 1-cycle delayed copy of iDisplayEn gates the read data. oPixel (registered) = iRamRData when the delayed enable is 1, else 0.
  - Net: the pixel for the column presented in cycle N appears on oPixel at the end of cycle N+1.
- States:
  - ST_IDLE: no clear pending. Non-display cycles drain the FIFO head if the FIFO is non-empty.
  - ST_CLEAR: each non-display cycle writes iClearColor_latched at clear address, then increments it.
    - After writing address H_ACTIVE*V_ACTIVE-1, next state is ST_IDLE and the clear address returns to 0.
    - The FIFO is not drained while in ST_CLEAR but still accepts pushes until full.
- Transitions: ST_IDLE -> ST_CLEAR on iClearReq=1. iClearReq in ST_CLEAR is ignored. oClearBusy = (state == ST_CLEAR).
- Drain rules:
  - Pop head: if head address < H_ACTIVE*V_ACTIVE, drive oRamWe=1 with the head address and data.
  - Otherwise, no write and oDropCount increments, saturating at 255.
- No free slot: when neither a display read nor a write occurs, oRamAddr=0 and oRamWe=0.
- FIFO:
  - Push when iWrReq && !oWrFull. oWrFull = (count == FIFO_DEPTH).
  - Push and pop in the same cycle when not full: count unchanged, ordering preserved.
  - Push when full is rejected even if a pop occurs that cycle; the writer retries.
  - A write pushed in cycle N is eligible for drain no earlier than cycle N+1. No bypass.
- iColumn >= H_ACTIVE while iDisplayEn=1 is a timing error: the address is still computed and no protection is applied.

Test Plan:
- Reset with FIFO holding 3 entries, then release -> oWrFull=0, no oRamWe for 10 blank cycles, oPixel=0, oDropCount=0.
- Display readback: preload VRAM[1*64+5]=3'b101, drive iRow=1, iColumn=5, iDisplayEn=1 in cycle N -> oRamAddr=69 in N, oPixel=3'b101 after N+1; oPixel=0 one cycle after iDisplayEn falls.
- Writer during display: push 4 writes (addr 10..13, data 1..4) while iDisplayEn=1 -> oWrFull=1 after 4th, 5th rejected, no oRamWe; when iDisplayEn drops, writes land in order on 4 consecutive cycles and oWrFull clears after the first pop.
- Out-of-range: push addr 30720 (= 64*480) in blanking -> no oRamWe, oDropCount 0->1; 300 such writes -> oDropCount=255.
- Clear sweep interleaved with display: iClearReq with color 3'b010 -> every VRAM word reads 3'b010 at end; oClearBusy high until address 30719 written; no write when iDisplayEn=1; a second iClearReq mid-sweep ignored.
- Priority: FIFO non-empty during ST_CLEAR -> FIFO untouched until clear ends, then drains in the first blank cycle after oClearBusy falls.

Source files
------------

// File: rtl/vga_vram_arbiter.sv
// rtl/vga_vram_arbiter.sv - single-port VRAM arbiter for display reads, clear sweep and buffered writes
//
// Ports:
//   Clock, Reset                        system clock, synchronous active-high reset
//   iDisplayEn, iColumn, iRow           display timing; one pixel read per active cycle
//   iWrReq, iWrAddr, iWrData, oWrFull   writer request into the FIFO (ignored while full)
//   iClearReq, iClearColor, oClearBusy  clear-screen sweep start / fill value / in progress
//   oRamAddr, oRamWe, oRamWData         VRAM port, combinational
//   iRamRData                           VRAM read data, one cycle after the address
//   oPixel                              registered pixel to the DAC
//   oDropCount                          saturating count of discarded out-of-range writes
module vga_vram_arbiter #(
  parameter int H_ACTIVE   = 64,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iDisplayEn,
  input  logic [9:0]        iColumn,
  input  logic [9:0]        iRow,
  input  logic              iWrReq,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oWrFull,
  input  logic              iClearReq,
  input  logic [DATA_W-1:0] iClearColor,
  output logic              oClearBusy,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic              oRamWe,
  output logic [DATA_W-1:0] oRamWData,
  input  logic [DATA_W-1:0] iRamRData,
  output logic [DATA_W-1:0] oPixel,
  output logic [7:0]        oDropCount
);

  localparam int          PIX_TOTAL   = H_ACTIVE * V_ACTIVE;
  localparam logic [31:0] PIX_TOTAL_W = 32'(PIX_TOTAL);
  localparam int          COL_SH      = $clog2(H_ACTIVE);
  localparam int          PROD_W      = 10 + COL_SH + 1;
  localparam int          PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CNT_W       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]  clr_color_q, clr_color_d;
  logic [ADDR_W-1:0]  fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fifo_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [7:0]         drop_q, drop_d;
  logic               de_dly_q, de_dly_d;
  logic [DATA_W-1:0]  pixel_q, pixel_d;

  // ---------------------------------------------------------------------------
  // Slot decode signals
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]  disp_addr;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               head_in_range;
  logic               fifo_empty;
  logic               fifo_full;
  logic               clr_last;
  logic               clr_wr;
  logic               drain_pop;
  logic               push;
  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_we;
  logic [DATA_W-1:0]  ram_wdata;

  // Display address row*H_ACTIVE + column, formed one bit wider than the
  // largest term so the carry is kept before truncation to ADDR_W. Columns
  // beyond the visible width are not clamped; that is a timing-source error.
  generate
    if ((1 << COL_SH) == H_ACTIVE) begin : g_shift_add
      assign disp_addr = ADDR_W'({1'b0, iRow, {COL_SH{1'b0}}}
                                 + {{(COL_SH + 1){1'b0}}, iColumn});
    end else begin : g_mul_add
      assign disp_addr = ADDR_W'(PROD_W'(iRow) * PROD_W'(H_ACTIVE)
                                 + PROD_W'(iColumn));
    end
  endgenerate

  assign head_addr     = fifo_addr_q[rd_ptr_q];
  assign head_data     = fifo_data_q[rd_ptr_q];
  assign head_in_range = ({{(32 - ADDR_W){1'b0}}, head_addr} < PIX_TOTAL_W);
  assign fifo_empty    = (fifo_cnt_q == '0);
  assign fifo_full     = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign clr_last      = (clr_addr_q == ADDR_W'(PIX_TOTAL - 1));

  // A full FIFO rejects the request even if the head pops this cycle.
  assign push = iWrReq && !fifo_full;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (iClearReq) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // Requests during a sweep are ignored; leave only after the last word.
        if (clr_wr && clr_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / slot selection (display read > clear write > FIFO drain)
  // ---------------------------------------------------------------------------
  always_comb begin
    clr_wr    = 1'b0;
    drain_pop = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (iDisplayEn) begin
      ram_addr = disp_addr;
    end else if (!Reset) begin
      // Writes are suppressed in the reset cycle so an aborted sweep or
      // drain leaves no stray word in VRAM.
      if (state_q == ST_CLEAR) begin
        clr_wr    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_addr_q;
        ram_wdata = clr_color_q;
      end else if (!fifo_empty) begin
        drain_pop = 1'b1;
        if (head_in_range) begin
          ram_we    = 1'b1;
          ram_addr  = head_addr;
          ram_wdata = head_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    drop_d      = drop_q;
    de_dly_d    = iDisplayEn;
    pixel_d     = de_dly_q ? iRamRData : '0;

    if (state_q == ST_IDLE && iClearReq) begin
      clr_color_d = iClearColor;
    end

    if (clr_wr) begin
      clr_addr_d = clr_last ? '0 : clr_addr_q + ADDR_W'(1);
    end

    // The pushed entry lands at the tail; it cannot be the head popped in
    // the same cycle, so there is no write-through path.
    if (push) begin
      fifo_addr_d[wr_ptr_q] = iWrAddr;
      fifo_data_d[wr_ptr_q] = iWrData;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end

    if (drain_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (!head_in_range && drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end

    case ({push, drain_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      drop_q      <= '0;
      de_dly_q    <= 1'b0;
      pixel_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      drop_q      <= drop_d;
      de_dly_q    <= de_dly_d;
      pixel_q     <= pixel_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= fifo_addr_d[i];
        fifo_data_q[i] <= fifo_data_d[i];
      end
    end
  end

  assign oWrFull    = fifo_full;
  assign oClearBusy = (state_q == ST_CLEAR);
  assign oRamAddr   = ram_addr;
  assign oRamWe     = ram_we;
  assign oRamWData  = ram_wdata;
  assign oPixel     = pixel_q;
  assign oDropCount = drop_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb/tb_vga_vram_arbiter.sv - self-checking bench for vga_vram_arbiter
module tb_vga_vram_arbiter;

  localparam int H     = 64;
  localparam int V     = 480;
  localparam int AW    = 15;
  localparam int DW    = 3;
  localparam int DEPTH = 4;
  localparam int TOTAL = H * V;
  localparam int RAMSZ = 1 << AW;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iDisplayEn;
  logic [9:0]    iColumn;
  logic [9:0]    iRow;
  logic          iWrReq;
  logic [AW-1:0] iWrAddr;
  logic [DW-1:0] iWrData;
  logic          oWrFull;
  logic          iClearReq;
  logic [DW-1:0] iClearColor;
  logic          oClearBusy;
  logic [AW-1:0] oRamAddr;
  logic          oRamWe;
  logic [DW-1:0] oRamWData;
  logic [DW-1:0] iRamRData;
  logic [DW-1:0] oPixel;
  logic [7:0]    oDropCount;

  always #5 Clock = ~Clock;

  vga_vram_arbiter #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .iDisplayEn(iDisplayEn), .iColumn(iColumn), .iRow(iRow),
    .iWrReq(iWrReq), .iWrAddr(iWrAddr), .iWrData(iWrData), .oWrFull(oWrFull),
    .iClearReq(iClearReq), .iClearColor(iClearColor), .oClearBusy(oClearBusy),
    .oRamAddr(oRamAddr), .oRamWe(oRamWe), .oRamWData(oRamWData),
    .iRamRData(iRamRData), .oPixel(oPixel), .oDropCount(oDropCount)
  );

  // Synchronous single-port VRAM, read data one cycle after the address.
  logic          ram_init;
  logic [DW-1:0] vram [0:RAMSZ-1];
  logic [DW-1:0] ram_rdata;

  always @(posedge Clock) begin
    if (ram_init) begin
      for (int i = 0; i < RAMSZ; i++) vram[i] <= '0;
      ram_rdata <= '0;
    end else begin
      if (oRamWe) vram[oRamAddr] <= oRamWData;
      ram_rdata <= vram[oRamAddr];
    end
  end
  assign iRamRData = ram_rdata;

  // Reference model: pending writes queue, sweep progress, shadow VRAM.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           m_q[$];
  bit            m_busy;
  int            m_idx;
  logic [DW-1:0] m_color;
  int            m_drop;
  logic [DW-1:0] m_pix_stage;
  logic [DW-1:0] m_pix_out;
  logic [DW-1:0] ref_mem [0:RAMSZ-1];

  int checks;
  int errors;

  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_pix;
  logic          s_full;
  logic          s_busy;
  logic [7:0]    s_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy      = 1'b0;
    m_idx       = 0;
    m_color     = '0;
    m_drop      = 0;
    m_pix_stage = '0;
    m_pix_out   = '0;
  endtask

  task automatic drive(input logic de, input int row, input int col,
                       input logic wr, input int wa, input int wd);
    iDisplayEn = de;
    iRow       = 10'(row);
    iColumn    = 10'(col);
    iWrReq     = wr;
    iWrAddr    = AW'(wa);
    iWrData    = DW'(wd);
    iClearReq  = 1'b0;
  endtask

  // One clock: sample at the falling edge, compare with the model, advance
  // the model, then return just after the rising edge.
  task automatic step();
    int   e_addr;
    logic e_we;
    int   e_wdata;
    bit   was_busy;
    int   sz;
    wr_t  h;
    @(negedge Clock);
    s_addr  = oRamAddr;
    s_we    = oRamWe;
    s_wdata = oRamWData;
    s_pix   = oPixel;
    s_full  = oWrFull;
    s_busy  = oClearBusy;
    s_drop  = oDropCount;

    check("pixel", oPixel, m_pix_out);
    check("drop_count", oDropCount, m_drop);
    check("wr_full", oWrFull, (m_q.size() == DEPTH) ? 1 : 0);
    check("clear_busy", oClearBusy, m_busy);

    e_we = 1'b0;
    e_addr = 0;
    e_wdata = 0;
    if (iDisplayEn) begin
      e_addr = (int'(iRow) * H + int'(iColumn)) % RAMSZ;
    end else if (!Reset && m_busy) begin
      e_we = 1'b1; e_addr = m_idx; e_wdata = int'(m_color);
    end else if (!Reset && m_q.size() > 0) begin
      h = m_q[0];
      if (int'(h.a) < TOTAL) begin
        e_we = 1'b1; e_addr = int'(h.a); e_wdata = int'(h.d);
      end
    end
    check("ram_we", oRamWe, e_we);
    check("ram_addr", oRamAddr, e_addr);
    if (e_we) check("ram_wdata", oRamWData, e_wdata);

    if (Reset) begin
      model_reset();
    end else begin
      was_busy    = m_busy;
      sz          = m_q.size();
      m_pix_out   = m_pix_stage;
      m_pix_stage = iDisplayEn ? ref_mem[e_addr] : '0;
      if (!iDisplayEn && was_busy) begin
        ref_mem[m_idx] = m_color;
        m_idx++;
        if (m_idx == TOTAL) begin
          m_busy = 1'b0;
          m_idx  = 0;
        end
      end else if (!iDisplayEn && sz > 0) begin
        h = m_q.pop_front();
        if (int'(h.a) < TOTAL) ref_mem[h.a] = h.d;
        else if (m_drop < 255) m_drop++;
      end
      if (iWrReq && sz < DEPTH) begin
        h.a = iWrAddr;
        h.d = iWrData;
        m_q.push_back(h);
      end
      if (!was_busy && iClearReq) begin
        m_busy  = 1'b1;
        m_color = iClearColor;
      end
    end
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    logic de;
    int   row;
    int   col;
    int   exp_addr;
    logic exp_we;
  } vec_t;

  vec_t vt [7];

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int de_r;
    checks = 0;
    errors = 0;

    vt[0] = '{1'b1, 0,   0,   0,     1'b0};
    vt[1] = '{1'b1, 1,   5,   69,    1'b0};
    vt[2] = '{1'b1, 2,   0,   128,   1'b0};
    vt[3] = '{1'b1, 479, 63,  30719, 1'b0};
    vt[4] = '{1'b0, 100, 10,  0,     1'b0};
    vt[5] = '{1'b1, 0,   70,  70,    1'b0};
    vt[6] = '{1'b1, 479, 100, 30756, 1'b0};

    for (int i = 0; i < RAMSZ; i++) ref_mem[i] = '0;
    model_reset();
    Reset       = 1'b1;
    ram_init    = 1'b1;
    iClearColor = '0;
    drive(1'b0, 0, 0, 1'b0, 0, 0);
    @(posedge Clock);
    #1;
    ram_init = 1'b0;
    step();
    Reset = 1'b0;

    // Reset state
    drive(1'b0, 0, 0, 1'b0, 0, 0);
    step();
    check("rst_full", s_full, 0);
    check("rst_busy", s_busy, 0);
    check("rst_pixel", s_pix, 0);
    check("rst_drop", s_drop, 0);
    check("rst_idle_addr", s_addr, 0);

    // Address vectors from idle with an empty FIFO
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].de, vt[i].row, vt[i].col, 1'b0, 0, 0);
      step();
      check("vec_addr", s_addr, vt[i].exp_addr);
      check("vec_we", s_we, vt[i].exp_we);
    end

    // Reset while the FIFO holds three entries
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 0, k, 1'b1, 100 + k, k + 1);
      step();
    end
    drive(1'b0, 0, 0, 1'b0, 0, 0);
    Reset = 1'b1;
    step();
    check("rst_cycle_no_we", s_we, 0);
    Reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 0, 0, 1'b0, 0, 0);
      step();
      check("post_rst_no_we", s_we, 0);
      check("post_rst_full", s_full, 0);
      check("post_rst_pixel", s_pix, 0);
      check("post_rst_drop", s_drop, 0);
    end

    // Display readback of VRAM[69]
    drive(1'b0, 0, 0, 1'b1, 69, 5);
    step();
    drive(1'b0, 0, 0, 1'b0, 0, 0);
    step();
    check("preload_we", s_we, 1);
    check("preload_addr", s_addr, 69);
    drive(1'b1, 1, 5, 1'b0, 0, 0);
    step();
    check("readback_addr", s_addr, 69);
    check("readback_we", s_we, 0);
    drive(1'b0, 0, 0, 1'b0, 0, 0);
    step();
    step();
    check("readback_pixel", s_pix, 5);
    step();
    check("pixel_after_de_low", s_pix, 0);

    // Writer during display: fill, reject, then drain in order
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3, k, 1'b1, 10 + k, 1 + k);
      step();
      check("disp_no_we", s_we, 0);
      check("fill_full", s_full, (k == 4) ? 1 : 0);
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 0, 0, 1'b0, 0, 0);
      step();
      check("drain_we", s_we, (k < 4) ? 1 : 0);
      if (k < 4) begin
        check("drain_addr", s_addr, 10 + k);
        check("drain_data", s_wdata, 1 + k);
      end
      check("drain_full", s_full, (k == 0) ? 1 : 0);
    end

    // Out-of-range writes are dropped and counted, saturating
    drive(1'b0, 0, 0, 1'b1, TOTAL, 6);
    step();
    drive(1'b0, 0, 0, 1'b0, 0, 0);
    step();
    check("oor_no_we", s_we, 0);
    check("oor_drop_before", s_drop, 0);
    step();
    check("oor_drop_after", s_drop, 1);
    for (int k = 0; k < 300; k++) begin
      drive(1'b0, 0, 0, 1'b1, TOTAL + (k % 100), k % 8);
      step();
    end
    drive(1'b0, 0, 0, 1'b0, 0, 0);
    step();
    step();
    step();
    check("drop_saturated", s_drop, 255);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, V - 1), $urandom_range(0, H - 1),
            1'($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0) ? $urandom_range(TOTAL, RAMSZ - 1)
                                        : $urandom_range(0, TOTAL - 1),
            $urandom_range(0, 7));
      Reset = ($urandom_range(0, 499) == 0);
      step();
      Reset = 1'b0;
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 0, 0, 1'b0, 0, 0);
      step();
    end

    // Clear sweep interleaved with display, FIFO held until it ends
    drive(1'b0, 0, 0, 1'b0, 0, 0);
    iClearReq   = 1'b1;
    iClearColor = 3'b010;
    step();
    iClearReq = 1'b0;
    check("clear_busy_start", oClearBusy, 1);
    n = 0;
    while (n < 40000 && oClearBusy) begin
      de_r = ($urandom_range(0, 7) == 0) ? 1 : 0;
      drive(1'(de_r), $urandom_range(0, V - 1), $urandom_range(0, H - 1),
            1'(n == 2000 || n == 2001), (n == 2000) ? 7 : 8, (n == 2000) ? 7 : 1);
      if (n == 1000) begin
        iClearReq   = 1'b1;
        iClearColor = 3'b101;
      end
      step();
      iClearReq = 1'b0;
      n++;
    end
    check("clear_done_in_bound", oClearBusy, 0);
    check("clear_last_we", s_we, 1);
    check("clear_last_addr", s_addr, TOTAL - 1);
    check("clear_last_data", s_wdata, 3'b010);
    check("clear_busy_at_last", s_busy, 1);

    for (int k = 0; k < 3; k++) begin
      drive(1'b1, $urandom_range(0, V - 1), $urandom_range(0, H - 1), 1'b0, 0, 0);
      step();
      check("post_clear_disp_no_we", s_we, 0);
    end
    bad = 0;
    for (int a = 0; a < TOTAL; a++) begin
      if (vram[a] !== 3'b010) bad++;
    end
    check("vram_all_cleared", bad, 0);

    drive(1'b0, 0, 0, 1'b0, 0, 0);
    step();
    check("held_drain0_we", s_we, 1);
    check("held_drain0_addr", s_addr, 7);
    check("held_drain0_data", s_wdata, 7);
    step();
    check("held_drain1_addr", s_addr, 8);
    check("held_drain1_data", s_wdata, 1);
    step();
    check("held_drain_done", s_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
